// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared encodings for the counter command sequencer:
//                command opcodes, FSM state codes and counter limits.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

   // Default counter width and the largest value it can hold
   localparam int CNT_W_DEF = 3;
   localparam int CNT_MAX   = (2 ** CNT_W_DEF) - 1;

   // Command opcodes carried on cmd_op
   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_INC_N = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   // Sequencer FSM state codes
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_INC    = 2'd2;
   localparam logic [1:0] ST_SETTLE = 2'd3;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : counter_cmd_sequencer
//  Description : Expands LOAD / INC_N / CLEAR commands into single-cycle
//                ld / inc pulses for a loadable counter. A shadow copy of
//                the count stops inc from ever being issued at the maximum,
//                and the counter readback is checked against the shadow.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_cmd_sequencer
   import counter_pkg::*;
#(
   parameter int CNT_W = 3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_arg,
   output logic             ld,
   output logic             inc,
   output logic [CNT_W-1:0] data_in,
   input  logic [CNT_W-1:0] count_in,
   input  logic             err_clr,
   output logic             ovf_err,
   output logic             mis_err,
   output logic             busy
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_one     = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_shadow;
   logic [CNT_W-1:0] r_remaining;
   logic             r_ld;
   logic             r_inc;
   logic [CNT_W-1:0] r_data_in;
   logic             r_ovf_err;
   logic             r_mis_err;

   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_shadow_nxt;
   logic [CNT_W-1:0] w_remaining_nxt;
   logic [CNT_W-1:0] w_data_in_nxt;
   logic             w_accept;
   logic             w_ovf_set;
   logic             w_mis_set;

   // Next-state, shadow and remaining-count computation
   always_comb begin
      w_state_nxt     = r_state;
      w_shadow_nxt    = r_shadow;
      w_remaining_nxt = r_remaining;
      w_data_in_nxt   = r_data_in;
      w_ovf_set       = 1'b0;
      w_mis_set       = 1'b0;
      w_accept        = cmd_valid && (r_state == ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (cmd_op)
                  OP_LOAD: begin
                     w_state_nxt   = ST_LOAD;
                     w_data_in_nxt = cmd_arg;
                  end
                  OP_CLEAR: begin
                     w_state_nxt   = ST_LOAD;
                     w_data_in_nxt = '0;
                  end
                  OP_INC_N: begin
                     if (cmd_arg == '0) begin
                        w_state_nxt = ST_SETTLE;
                     end else begin
                        w_state_nxt     = ST_INC;
                        w_remaining_nxt = cmd_arg;
                     end
                  end
                  default: w_state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_LOAD: begin
            // The counter loads on this same edge, so the shadow follows it
            w_shadow_nxt = r_data_in;
            w_state_nxt  = ST_SETTLE;
         end
         ST_INC: begin
            if (r_shadow != c_cnt_max) begin
               w_shadow_nxt    = r_shadow + c_one;
               w_remaining_nxt = r_remaining - c_one;
               if (r_remaining == c_one) begin
                  w_state_nxt = ST_SETTLE;
               end
            end else begin
               // Saturated: drop the outstanding increments rather than wrap
               w_ovf_set       = 1'b1;
               w_remaining_nxt = '0;
               w_state_nxt     = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            w_mis_set   = (count_in != r_shadow);
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, shadow and registered counter-control outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_shadow    <= '0;
         r_remaining <= '0;
         r_ld        <= 1'b0;
         r_inc       <= 1'b0;
         r_data_in   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_shadow    <= w_shadow_nxt;
         r_remaining <= w_remaining_nxt;
         r_data_in   <= w_data_in_nxt;
         // Pulses are decided one cycle early so they leave a flop
         r_ld        <= (w_state_nxt == ST_LOAD);
         r_inc       <= (w_state_nxt == ST_INC) && (w_shadow_nxt != c_cnt_max);
      end
   end

   // Sticky error flags; a set event wins over a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf_err <= 1'b0;
         r_mis_err <= 1'b0;
      end else begin
         r_ovf_err <= w_ovf_set | (r_ovf_err & ~err_clr);
         r_mis_err <= w_mis_set | (r_mis_err & ~err_clr);
      end
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = ~cmd_ready;
   assign ld        = r_ld;
   assign inc       = r_inc;
   assign data_in   = r_data_in;
   assign ovf_err   = r_ovf_err;
   assign mis_err   = r_mis_err;

endmodule : counter_cmd_sequencer
`default_nettype wire

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
- Upstream control stage for the 3-bit loadable counter. Drives its ld, inc and data_in pins.
- Accepts LOAD / INC_N / CLEAR commands over a valid/ready handshake and expands each into single-cycle ld/inc pulses.
- Keeps a shadow copy of the count so that inc is never issued at 7, which guarantees the counter's overflow check never fires.
- Reads the counter's data_out back and raises a sticky error on any mismatch with the shadow.

Parameters:
- CNT_W, 3, width of the counter, data_in, cmd_arg and shadow count.

Ports:
- clk  in  1  rising-edge clock, shared with the counter
- rst  in  1  synchronous, active-high reset, shared with the counter
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command this cycle
- cmd_op  in  2  00 NOP, 01 LOAD, 10 INC_N, 11 CLEAR
- cmd_arg  in  CNT_W  load value (LOAD) or increment count N (INC_N)
- ld  out  1  to counter ld, registered
- inc  out  1  to counter inc, registered
- data_in  out  CNT_W  to counter data_in, registered
- count_in  in  CNT_W  from counter data_out
- err_clr  in  1  clears both sticky error flags
- ovf_err  out  1  sticky: an INC_N was truncated at the maximum count
- mis_err  out  1  sticky: readback did not match the shadow
- busy  out  1  equals ~cmd_ready

Behaviour:
- Reset (rst=1 at posedge): state IDLE, shadow=0, remaining=0, ld=0, inc=0, data_in=0, ovf_err=0, mis_err=0, cmd_ready=1. Reset mid-command aborts it with no further pulses.
- FSM states: IDLE, LOAD, INC, SETTLE.
- IDLE:
  - cmd_ready=1; a command is accepted when cmd_valid & cmd_ready.
  - NOP stays in IDLE.
  - LOAD goes to LOAD with data_in<=cmd_arg.
  - CLEAR goes to LOAD with data_in<=0.
  - INC_N with arg=0 goes to SETTLE.
  - INC_N with arg>0 sets remaining<=arg and goes to INC.
- LOAD:
  - ld=1 for exactly one cycle; shadow<=data_in at the end of the cycle.
  - Next state SETTLE.
- INC (each cycle):
  - If shadow < 2^CNT_W-1: inc=1, shadow<=shadow+1, remaining<=remaining-1. If remaining==1, the next state is SETTLE.
  - If shadow == 2^CNT_W-1: inc=0, ovf_err<=1, remaining<=0, next state SETTLE. The unissued increments are dropped, never wrapped.
- SETTLE:
  - One cycle, ld=inc=0. The counter has already updated, so if count_in != shadow then mis_err<=1.
  - Next state IDLE.
- ld and inc are never asserted in the same cycle. inc is never asserted while shadow is at maximum.
- Latency, command accepted at cycle t:
  - LOAD/CLEAR: ld at t+1, SETTLE at t+2, cmd_ready=1 at t+3.
  - INC_N of k with no saturation: inc at t+1..t+k, SETTLE at t+k+1, ready at t+k+2.
  - INC_N of 0: SETTLE at t+1.
- cmd_ready=0 in every state except IDLE. cmd_valid while not ready is ignored and not queued.
- Sticky flags: err_clr=1 clears both at the next edge. A set event in the same cycle as err_clr wins (the flag reads 1).
- Arithmetic: all CNT_W-bit unsigned; the shadow never wraps.

Decomposition:
- Shared package counter_pkg:
  - cmd_op encodings: OP_NOP, OP_LOAD, OP_INC_N, OP_CLEAR.
  - State encoding: IDLE, LOAD, INC, SETTLE.
  - CNT_MAX = 2^CNT_W-1.
- No sub-module; a single FSM with a shadow register and a remaining counter.
- Top-level test wrapper seq_counter_top instantiates counter_cmd_sequencer plus threebitcounter and connects count_in to data_out.

Test Plan:
- Reset, then LOAD 5 -> ld=1 for one cycle at t+1 with data_in=5; count_in=5 at t+2; mis_err=0; cmd_ready at t+3.
- LOAD 2, then INC_N 3 -> inc=1 for three consecutive cycles; count_in=5; ovf_err=0; ready 5 cycles after acceptance.
- LOAD 5, then INC_N 4 -> exactly two inc pulses; count_in=7; ovf_err=1; counter's "Assertion Error" never printed.
- err_clr pulsed while idle -> ovf_err=0. Repeat the saturating case with err_clr held during the saturate cycle -> ovf_err remains 1.
- Force count_in to 0 in the wrapper during SETTLE after LOAD 3 -> mis_err=1.
- INC_N 6 from 0, rst asserted after the 2nd inc -> next cycle all outputs 0, shadow=0, cmd_ready=1, no further inc.
